// File: rtl/ep_chn_arb.sv
// ep_chn_arb: round-robin TRN tx token arbiter across NCH channels.
// Optional `EP_ARB_ERR_EN adds a sticky bus-protocol error flag.
module ep_chn_arb #(
  parameter int NCH = 2,
  parameter int CW  = 1,
  parameter int TMO = 15
) (
  input  logic           pcie_clk,
  input  logic           pcie_rst,
  input  logic [NCH-1:0] chn_reqep,
  input  logic [NCH-1:0] chn_drvn,
  output logic [NCH-1:0] chn_trn,
  output logic [CW-1:0]  cur_chn,
  output logic           arb_busy,
  output logic           arb_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_BUSY,
    S_GAP
  } state_t;

  state_t         state_q, state_d;
  logic [NCH-1:0] trn_q, trn_d;
  logic [CW-1:0]  cur_q, cur_d;
  logic           busy_q, busy_d;
  logic [7:0]     cnt_q, cnt_d;

  logic [NCH-1:0] own_oh;
  logic           own_drv;
  logic           own_req;
  logic           found;
  logic [CW-1:0]  sel;
  logic [NCH-1:0] rot;
  int             idx;

  assign own_oh  = NCH'(1) << cur_q;
  assign own_drv = |(chn_drvn & own_oh);
  assign own_req = |(chn_reqep & own_oh);

  // Scan starts one past the last owner so it drops to lowest priority.
  always_comb begin
    found = 1'b0;
    sel   = cur_q;
    idx   = 0;
    rot   = '0;
    for (int i = 1; i <= NCH; i++) begin
      idx = (int'(cur_q) + i) % NCH;
      rot = chn_reqep >> idx;
      if (!found && rot[0]) begin
        found = 1'b1;
        sel   = CW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    trn_d   = trn_q;
    cur_d   = cur_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          trn_d   = NCH'(1) << sel;
          cur_d   = sel;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (own_drv) begin
          state_d = S_BUSY;
        end else if (!own_req || cnt_q == 8'(TMO - 1)) begin
          trn_d   = '0;
          busy_d  = 1'b0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_BUSY: begin
        if (!own_drv) begin
          trn_d   = '0;
          busy_d  = 1'b0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        trn_d   = '0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge pcie_clk) begin
    if (pcie_rst) begin
      state_q <= S_IDLE;
      trn_q   <= '0;
      cur_q   <= CW'(NCH - 1);
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      trn_q   <= trn_d;
      cur_q   <= cur_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign chn_trn  = trn_q;
  assign cur_chn  = cur_q;
  assign arb_busy = busy_q;

`ifdef EP_ARB_ERR_EN
  logic           err_q, err_d;
  logic [NCH-1:0] legal;

  // The owner may drive before its token is seen only while WAIT/BUSY.
  always_comb begin
    legal = trn_q;
    if (state_q == S_BUSY || state_q == S_WAIT) begin
      legal = legal | own_oh;
    end
    err_d = err_q
          | (|(chn_drvn & ~legal))
          | ((chn_drvn & (chn_drvn - NCH'(1))) != '0);
  end

  always_ff @(posedge pcie_clk) begin
    if (pcie_rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign arb_err = err_q;
`else
  assign arb_err = 1'b0;
`endif

endmodule

// File: tb/tb_ep_chn_arb.sv
// tb_ep_chn_arb: directed checks of token grant, release, timeout,
// round-robin wrap, reset and the optional error flag.
module tb_ep_chn_arb;

`ifdef EP_ARB_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req2 = '0;
  logic [1:0] drv2 = '0;
  logic [1:0] trn2;
  logic       cur2;
  logic       busy2;
  logic       err2;
  logic [2:0] req3 = '0;
  logic [2:0] drv3 = '0;
  logic [2:0] trn3;
  logic [1:0] cur3;
  logic       busy3;
  logic       err3;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ep_chn_arb #(.NCH(2), .CW(1), .TMO(15)) u2 (
    .pcie_clk (clk),
    .pcie_rst (rst),
    .chn_reqep(req2),
    .chn_drvn (drv2),
    .chn_trn  (trn2),
    .cur_chn  (cur2),
    .arb_busy (busy2),
    .arb_err  (err2)
  );

  ep_chn_arb #(.NCH(3), .CW(2), .TMO(4)) u3 (
    .pcie_clk (clk),
    .pcie_rst (rst),
    .chn_reqep(req3),
    .chn_drvn (drv3),
    .chn_trn  (trn3),
    .cur_chn  (cur3),
    .arb_busy (busy3),
    .arb_err  (err3)
  );

  typedef struct {
    logic       rst;
    logic [1:0] req;
    logic [1:0] drv;
    logic [1:0] trn;
    logic       cur;
    logic       busy;
  } vec_t;

  vec_t tv[23];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    // rst req drv -> trn cur busy
    tv[0]  = '{1'b1, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
    tv[1]  = '{1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
    tv[2]  = '{1'b0, 2'b01, 2'b00, 2'b01, 1'b0, 1'b1};
    tv[3]  = '{1'b0, 2'b01, 2'b01, 2'b01, 1'b0, 1'b1};
    tv[4]  = '{1'b0, 2'b01, 2'b01, 2'b01, 1'b0, 1'b1};
    tv[5]  = '{1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    tv[6]  = '{1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    tv[7]  = '{1'b0, 2'b11, 2'b00, 2'b10, 1'b1, 1'b1};
    tv[8]  = '{1'b0, 2'b11, 2'b10, 2'b10, 1'b1, 1'b1};
    tv[9]  = '{1'b0, 2'b11, 2'b10, 2'b10, 1'b1, 1'b1};
    tv[10] = '{1'b0, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0};
    tv[11] = '{1'b0, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0};
    tv[12] = '{1'b0, 2'b11, 2'b00, 2'b01, 1'b0, 1'b1};
    tv[13] = '{1'b0, 2'b11, 2'b01, 2'b01, 1'b0, 1'b1};
    tv[14] = '{1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0};
    tv[15] = '{1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0};
    tv[16] = '{1'b0, 2'b11, 2'b00, 2'b10, 1'b1, 1'b1};
    tv[17] = '{1'b0, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0};
    tv[18] = '{1'b0, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0};
    tv[19] = '{1'b0, 2'b01, 2'b00, 2'b01, 1'b0, 1'b1};
    tv[20] = '{1'b0, 2'b01, 2'b10, 2'b01, 1'b0, 1'b1};
    tv[21] = '{1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    tv[22] = '{1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};

    tick();
    tick();

    // grant/release, alternation, withdraw, non-owner drive
    for (int i = 0; i < 23; i++) begin
      rst  = tv[i].rst;
      req2 = tv[i].req;
      drv2 = tv[i].drv;
      tick();
      chk($sformatf("v%0d_trn", i), 32'(trn2), 32'(tv[i].trn));
      chk($sformatf("v%0d_cur", i), 32'(cur2), 32'(tv[i].cur));
      chk($sformatf("v%0d_busy", i), 32'(busy2), 32'(tv[i].busy));
    end

    // timeout: ch1 never drives
    req2 = 2'b10;
    tick();
    chk("tmo_grant", 32'(trn2), 32'(2'b10));
    chk("tmo_cur", 32'(cur2), 32'(1'b1));
    req2 = 2'b11;
    for (int k = 1; k < 15; k++) begin
      tick();
      chk($sformatf("tmo_hold%0d", k), 32'(trn2), 32'(2'b10));
    end
    tick();
    chk("tmo_drop", 32'(trn2), 32'(2'b00));
    chk("tmo_busy", 32'(busy2), 32'(1'b0));
    tick();
    chk("tmo_idle", 32'(trn2), 32'(2'b00));
    tick();
    chk("tmo_next", 32'(trn2), 32'(2'b01));
    chk("tmo_next_cur", 32'(cur2), 32'(1'b0));

    // reset pulse while BUSY
    drv2 = 2'b01;
    tick();
    chk("rst_busy", 32'(trn2), 32'(2'b01));
    rst = 1'b1;
    tick();
    chk("rst_trn", 32'(trn2), 32'(2'b00));
    chk("rst_cur", 32'(cur2), 32'(1'b1));
    chk("rst_busyflag", 32'(busy2), 32'(1'b0));
    rst  = 1'b0;
    req2 = 2'b10;
    drv2 = 2'b00;
    tick();
    chk("rst_regrant", 32'(trn2), 32'(2'b10));
    chk("rst_regrant_cur", 32'(cur2), 32'(1'b1));
    req2 = 2'b00;
    tick();
    tick();

    // NCH=3 wrap-around
    chk("w_cur0", 32'(cur3), 32'(2'd2));
    req3 = 3'b100;
    tick();
    chk("w_g2", 32'(trn3), 32'(3'b100));
    drv3 = 3'b100;
    tick();
    chk("w_b2", 32'(trn3), 32'(3'b100));
    drv3 = 3'b000;
    req3 = 3'b011;
    tick();
    chk("w_gap", 32'(trn3), 32'(3'b000));
    tick();
    chk("w_idle", 32'(trn3), 32'(3'b000));
    tick();
    chk("w_g0", 32'(trn3), 32'(3'b001));
    chk("w_c0", 32'(cur3), 32'(2'd0));
    req3 = 3'b010;
    tick();
    chk("w_gap2", 32'(trn3), 32'(3'b000));
    tick();
    tick();
    chk("w_g1", 32'(trn3), 32'(3'b010));
    chk("w_c1", 32'(cur3), 32'(2'd1));
    req3 = 3'b000;

    // error flag
    rst = 1'b1;
    tick();
    chk("e_rst", 32'(err2), 32'(1'b0));
    rst  = 1'b0;
    req2 = 2'b01;
    tick();
    chk("e_grant", 32'(trn2), 32'(2'b01));
    chk("e_clean", 32'(err2), 32'(1'b0));
    drv2 = 2'b11;
    tick();
    chk("e_set", 32'(err2), 32'(ERR_EN));
    drv2 = 2'b01;
    tick();
    chk("e_sticky1", 32'(err2), 32'(ERR_EN));
    drv2 = 2'b00;
    req2 = 2'b00;
    tick();
    chk("e_sticky2", 32'(err2), 32'(ERR_EN));
    chk("e_rel", 32'(trn2), 32'(2'b00));
    rst = 1'b1;
    tick();
    chk("e_clr", 32'(err2), 32'(1'b0));
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
